// File: rtl/video_stream_checker.sv
// AXI4-Stream video sink for the test-pattern generator: drives a rotating tready
// stall pattern, locks to the first start-of-frame and checks line/frame geometry and pixel data.
module video_stream_checker #(
  parameter int WIDTH      = 640,
  parameter int HEIGHT     = 480,
  parameter bit CHECK_DATA = 1'b1
) (
  input  logic        s_axis_vid_aclk,
  input  logic        aresetn,
  input  logic [31:0] s_axis_vid_tdata,
  input  logic        s_axis_vid_tlast,
  input  logic [0:0]  s_axis_vid_tuser,
  input  logic        s_axis_vid_tvalid,
  output logic        s_axis_vid_tready,
  input  logic [7:0]  stall_pattern,
  input  logic        clear_stats,
  output logic        locked,
  output logic [15:0] frame_count,
  output logic [15:0] sof_err_count,
  output logic [15:0] line_err_count,
  output logic [15:0] data_err_count,
  output logic [15:0] last_line_len,
  output logic        err_pulse,
  output logic [15:0] dbg_x,
  output logic [15:0] dbg_y,
  output logic [2:0]  dbg_state
);

  localparam logic [2:0]  ST_HUNT   = 3'b000;
  localparam logic [2:0]  ST_LOCKED = 3'b001;
  localparam logic [15:0] X_LAST    = 16'(WIDTH - 1);
  localparam logic [15:0] Y_LAST    = 16'(HEIGHT - 1);

  logic [2:0]  state_q, state_d;
  logic [2:0]  phase_q, phase_d;
  logic        tready_q, tready_d;
  logic [15:0] x_q, x_d, y_q, y_d;
  logic        miss_q, miss_d;
  logic [15:0] frame_q, frame_d;
  logic [15:0] sof_cnt_q, sof_cnt_d;
  logic [15:0] line_cnt_q, line_cnt_d;
  logic [15:0] data_cnt_q, data_cnt_d;
  logic [15:0] len_q, len_d;
  logic        err_pulse_q, err_pulse_d;

  function automatic logic [15:0] sat_inc(input logic [15:0] v, input logic inc);
    return (inc && v != 16'hFFFF) ? v + 16'd1 : v;
  endfunction

  logic        accept, take, chk, resync, frame_inc;
  logic        sof_err, line_err, data_err;
  logic [15:0] ex, ey;

  // NOTE: every signal assigned in this block gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q + 3'd1;
    tready_d    = ~stall_pattern[phase_q];
    x_d         = x_q;
    y_d         = y_q;
    miss_d      = miss_q;
    frame_d     = frame_q;
    len_d       = len_q;
    err_pulse_d = 1'b0;
    accept      = s_axis_vid_tvalid && tready_q;
    take        = 1'b0;
    chk         = (state_q == ST_LOCKED);
    resync      = 1'b0;
    frame_inc   = 1'b0;
    sof_err     = 1'b0;
    line_err    = 1'b0;
    data_err    = 1'b0;
    ex          = x_q;
    ey          = y_q;

    if (accept) begin
      if (!chk) begin
        if (s_axis_vid_tuser[0]) begin
          state_d = ST_LOCKED;
          take    = 1'b1;
          resync  = 1'b1;
        end
      end else begin
        take = 1'b1;
        if (s_axis_vid_tuser[0] && (x_q != 16'd0 || y_q != 16'd0)) begin
          sof_err = 1'b1;
          resync  = 1'b1;
        end else if (!s_axis_vid_tuser[0] && x_q == 16'd0 && y_q == 16'd0) begin
          sof_err = 1'b1;
        end
      end
    end

    if (resync) begin
      ex = 16'd0;
      ey = 16'd0;
    end

    if (take) begin
      data_err = chk && CHECK_DATA && (s_axis_vid_tdata != {ey, ex});
      if (s_axis_vid_tlast) begin
        len_d    = ex + 16'd1;
        x_d      = 16'd0;
        miss_d   = 1'b0;
        line_err = chk && (ex != X_LAST);
        if (ey == Y_LAST) begin
          y_d       = 16'd0;
          frame_inc = 1'b1;
        end else begin
          y_d = ey + 16'd1;
        end
      end else begin
        x_d    = ex + 16'd1;
        y_d    = ey;
        miss_d = resync ? 1'b0 : miss_q;
        // A line overrunning WIDTH is reported once, not on every extra beat.
        if (ex == X_LAST && !miss_d) begin
          line_err = chk;
          miss_d   = 1'b1;
        end
      end
    end

    err_pulse_d = sof_err || line_err || data_err;
    frame_d     = frame_q + {15'd0, frame_inc};
    sof_cnt_d   = sat_inc(sof_cnt_q, sof_err);
    line_cnt_d  = sat_inc(line_cnt_q, line_err);
    data_cnt_d  = sat_inc(data_cnt_q, data_err);

    if (clear_stats) begin
      frame_d    = 16'd0;
      sof_cnt_d  = 16'd0;
      line_cnt_d = 16'd0;
      data_cnt_d = 16'd0;
      len_d      = 16'd0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge s_axis_vid_aclk) begin
    if (!aresetn) begin
      state_q     <= ST_HUNT;
      phase_q     <= 3'd0;
      tready_q    <= 1'b0;
      x_q         <= 16'd0;
      y_q         <= 16'd0;
      miss_q      <= 1'b0;
      frame_q     <= 16'd0;
      sof_cnt_q   <= 16'd0;
      line_cnt_q  <= 16'd0;
      data_cnt_q  <= 16'd0;
      len_q       <= 16'd0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      tready_q    <= tready_d;
      x_q         <= x_d;
      y_q         <= y_d;
      miss_q      <= miss_d;
      frame_q     <= frame_d;
      sof_cnt_q   <= sof_cnt_d;
      line_cnt_q  <= line_cnt_d;
      data_cnt_q  <= data_cnt_d;
      len_q       <= len_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign s_axis_vid_tready = tready_q;
  assign locked            = (state_q == ST_LOCKED);
  assign frame_count       = frame_q;
  assign sof_err_count     = sof_cnt_q;
  assign line_err_count    = line_cnt_q;
  assign data_err_count    = data_cnt_q;
  assign last_line_len     = len_q;
  assign err_pulse         = err_pulse_q;
  assign dbg_x             = x_q;
  assign dbg_y             = y_q;
  assign dbg_state         = state_q;

endmodule

// File: doc/video_stream_checker.md
# video_stream_checker

AXI4-Stream video sink that consumes the pixel stream produced by the on-board test-pattern generator (tdata = {y[15:0], x[15:0]}, tuser = start of frame, tlast = end of line). It drives tready with a programmable stall pattern, locks to the first start-of-frame, and checks frame geometry and pixel content. It exposes saturating error counters and debug position outputs for ILA/bench observation. It sits at the far end of the video pipeline in test builds, in place of the video output/VDMA.

## Interface
- WIDTH, 640, active pixels per line
- HEIGHT, 480, lines per frame
- CHECK_DATA, 1, 1 = compare tdata against expected {y,x}; 0 = geometry checks only
- s_axis_vid_aclk  in  1  stream clock; all logic on rising edge
- aresetn  in  1  synchronous, active-low reset
- s_axis_vid_tdata  in  32  pixel word
- s_axis_vid_tlast  in  1  end of line
- s_axis_vid_tuser  in  1  ([0:0]) start of frame
- s_axis_vid_tvalid  in  1  beat valid
- s_axis_vid_tready  out  1  sink ready
- stall_pattern  in  8  bit i = 1 deasserts tready in phase i of an 8-cycle rotation
- clear_stats  in  1  synchronous clear of all counters (not lock)
- locked  out  1  1 once a SOF beat has been accepted
- frame_count  out  16  completed frames, wraps
- sof_err_count  out  16  saturating
- line_err_count  out  16  saturating
- data_err_count  out  16  saturating
- last_line_len  out  16  beats in the most recently terminated line
- err_pulse  out  1  one-cycle pulse on any error in an accepted beat
- dbg_x, dbg_y  out  16 each  expected position of next beat
- dbg_state  out  3  {000 HUNT, 001 LOCKED}

## Operation
- Accept = tvalid && tready at a rising edge. Only accepted beats affect state.
- Phase counter: 3-bit free-running, 0 after reset. tready is registered: tready <= ~stall_pattern[phase].
- HUNT: ignore beats until tuser=1 is accepted. That beat is pixel (0,0). Go to LOCKED and set locked=1. No error checks in HUNT.
- LOCKED, per accepted beat, checked against expected (x,y) before update:
  - tuser=1 and (x,y)!=(0,0): sof_err. Resync by treating the beat as (0,0).
  - tuser=0 and (x,y)==(0,0): sof_err. Continue without resync.
  - CHECK_DATA=1 and tdata != {y,x} (after any SOF resync): data_err.
  - tlast=1: last_line_len <= x+1, x <= 0.
    - If x != WIDTH-1: line_err (short).
    - If y == HEIGHT-1: y <= 0 and frame_count++. Otherwise y++.
  - tlast=0: x++ (16-bit, wraps).
    - If x == WIDTH-1: line_err (missing tlast), flagged once per line.
- Multiple errors in one beat increment each relevant counter. err_pulse is asserted once.
- Counters saturate at 0xFFFF. frame_count wraps.
- clear_stats clears the four counters, frame_count and last_line_len. It wins over a simultaneous increment. State, x and y are unaffected.

## Timing
- Reset values: tready=0, locked=0, all counters 0, last_line_len=0, err_pulse=0, dbg_x=dbg_y=0, dbg_state=HUNT, phase=0.
- tready first rises on the cycle after aresetn is sampled high, provided stall_pattern[0]=0.
- tready latency: tready reflects stall_pattern[phase] with one cycle of register latency. The source must not depend on tready combinationally.
- Counters, dbg_x/dbg_y and err_pulse update at the accepting edge and are visible on the following cycle. err_pulse stays high for exactly one cycle per erroneous beat.
- Reset asserted mid-frame: at the next edge, return to HUNT with all outputs at reset values. The partial frame is discarded and not counted.
- A tvalid beat with tready=0 is not consumed. The source must hold it; the checker does not check holding.

## Test plan
- WIDTH=8, HEIGHT=4, stall_pattern=0, clean stream of 3 frames starting with SOF -> frame_count=3, all error counts 0, last_line_len=8, locked=1.
- Stream beginning mid-frame at (3,2) -> no counts until the SOF beat. Then locked=1 and one clean frame gives frame_count=1 with 0 errors.
- stall_pattern=8'b1010_0101, clean 2 frames -> tready low in phases 0,2,5,7, frame_count=2, 0 errors, no beat lost or duplicated.
- Line 1 terminated with tlast at x=5 -> line_err_count=1, last_line_len=6, next beat expected at (0,2).
- tdata of pixel (4,1) corrupted to 0xDEADBEEF -> data_err_count=1, err_pulse high for 1 cycle. With CHECK_DATA=0 -> count stays 0.
- SOF asserted at (2,3) -> sof_err_count=1, resync to (0,0). Then clear_stats on the same cycle as an error -> counters read 0 afterwards.
